// File: rtl/image_receiver.sv
// image_receiver: UART (8N1) receive end of the image link.
// Deserialises bytes from a GPIO pin, pairs them into 12-bit pixels
// (high byte first), waits for the frame start marker and then streams
// NUM_PIXELS pixels into a frame-buffer write port.
//
// Handshake: there is no back-pressure. o_wr_en is a one-cycle strobe;
// o_wr_addr/o_wr_data are valid in that cycle and hold otherwise. The
// sink must accept a write in every cycle that o_wr_en is high.
//
// o_dbg_state = {frame_state, pixel_phase, rx_state[1:0]} for checkers.
module image_receiver #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          NUM_PIXELS   = 76800,
   parameter logic [11:0] START_PIXEL  = 12'h00A,
   parameter int          ADDR_W       = 17
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_uart_in,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [11:0]       o_wr_data,
   output logic              o_frame_active,
   output logic              o_frame_done,
   output logic              o_frame_err,
   output logic [7:0]        o_err_count,
   output logic [3:0]        o_dbg_state
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {PH_HIGH, PH_LOW} phase_t;
   typedef enum logic {FR_WAIT_SYNC, FR_RECEIVE} frame_state_t;

   // Synchroniser
   logic r_sync1;
   logic r_sync2;
   logic w_rx;

   // Byte receiver
   rx_state_t        r_rx_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             w_stop_tick;
   logic             w_byte_valid;
   logic             w_byte_err;

   // Pixel assembler
   phase_t      r_phase;
   logic [3:0]  r_hi_nib;
   logic        w_pix_valid;
   logic [11:0] w_pixel;
   logic        w_proto_err;

   // Frame tracker
   frame_state_t      r_frame_state;
   logic [ADDR_W-1:0] r_addr_cnt;
   logic              r_done_pend;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [11:0]       r_wr_data;
   logic              r_frame_active;
   logic              r_frame_done;
   logic              r_frame_err;
   logic [7:0]        r_err_count;

   // Two-flop synchroniser on the asynchronous serial line (idle high).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_uart_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx = r_sync2;

   // The byte strobes are decoded from the stop-bit sample point rather than
   // registered, so the pixel write lands exactly one cycle after that sample.
   assign w_stop_tick  = (r_rx_state == RX_STOP) && (r_bit_cnt == BIT_LAST);
   assign w_byte_valid = w_stop_tick && w_rx;
   assign w_byte_err   = w_stop_tick && !w_rx;

   // RX FSM: start-bit qualification at half a bit, then one sample per bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_state <= RX_IDLE;
         r_bit_cnt  <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
      end else begin
         case (r_rx_state)
            RX_IDLE: begin
               r_bit_cnt <= '0;
               if (!w_rx) r_rx_state <= RX_START;
            end
            RX_START: begin
               if (r_bit_cnt == HALF_LAST) begin
                  r_bit_cnt  <= '0;
                  r_bit_idx  <= '0;
                  // A line already back high is a glitch, not a start bit.
                  r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_bit_cnt == BIT_LAST) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {w_rx, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_bit_cnt == BIT_LAST) begin
                  // Back to IDLE immediately so a back-to-back start is seen.
                  r_bit_cnt  <= '0;
                  r_rx_state <= RX_IDLE;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   assign w_pix_valid = w_byte_valid && (r_phase == PH_LOW);
   assign w_pixel     = {r_hi_nib, r_shift};
   assign w_proto_err = w_byte_err ||
                        (w_byte_valid && (r_phase == PH_HIGH) && (r_shift[7:4] != 4'h0));

   // Pixel assembler: a high byte must carry a zero upper nibble; anything
   // else keeps us in HIGH so the stream resynchronises on the next byte.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase  <= PH_HIGH;
         r_hi_nib <= '0;
      end else if (w_byte_err) begin
         r_phase <= PH_HIGH;
      end else if (w_byte_valid) begin
         if (r_phase == PH_HIGH) begin
            if (r_shift[7:4] == 4'h0) begin
               r_hi_nib <= r_shift[3:0];
               r_phase  <= PH_LOW;
            end
         end else begin
            r_phase <= PH_HIGH;
         end
      end
   end

   // Frame FSM: marker detection, sequential writes, completion and abort.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_state  <= FR_WAIT_SYNC;
         r_addr_cnt     <= '0;
         r_done_pend    <= 1'b0;
         r_wr_en        <= 1'b0;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
         r_frame_active <= 1'b0;
         r_frame_done   <= 1'b0;
         r_frame_err    <= 1'b0;
         r_err_count    <= '0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_proto_err) begin
            // Abort without frame_done; pixels already written stay written.
            r_frame_err    <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_frame_state  <= FR_WAIT_SYNC;
            r_frame_active <= 1'b0;
            r_done_pend    <= 1'b0;
         end else if (r_done_pend) begin
            // Cycle after the final write: close the frame.
            r_done_pend    <= 1'b0;
            r_frame_done   <= 1'b1;
            r_frame_active <= 1'b0;
            r_frame_state  <= FR_WAIT_SYNC;
         end else if (w_pix_valid) begin
            case (r_frame_state)
               FR_WAIT_SYNC: begin
                  if (w_pixel == START_PIXEL) begin
                     r_frame_state  <= FR_RECEIVE;
                     r_addr_cnt     <= '0;
                     r_frame_active <= 1'b1;
                  end
               end
               FR_RECEIVE: begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_addr_cnt;
                  r_wr_data <= w_pixel;
                  // The counter stops at the last address instead of wrapping.
                  if (r_addr_cnt == ADDR_LAST) r_done_pend <= 1'b1;
                  else                         r_addr_cnt  <= r_addr_cnt + 1'b1;
               end
               default: r_frame_state <= FR_WAIT_SYNC;
            endcase
         end
      end
   end

   assign o_wr_en        = r_wr_en;
   assign o_wr_addr      = r_wr_addr;
   assign o_wr_data      = r_wr_data;
   assign o_frame_active = r_frame_active;
   assign o_frame_done   = r_frame_done;
   assign o_frame_err    = r_frame_err;
   assign o_err_count    = r_err_count;
   assign o_dbg_state    = {r_frame_state, r_phase, r_rx_state};

endmodule

// File: tb/tb_image_receiver.sv
// tb_image_receiver: bit-level UART driver, behavioural byte/pixel/frame
// model with an expected-write queue, negedge monitor and final report.
module tb_image_receiver;

   localparam int          CPB   = 8;
   localparam int          NPIX  = 4;
   localparam int          AW    = 17;
   localparam logic [11:0] START = 12'h00A;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_in = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [11:0]   wr_data;
   logic          frame_active;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    err_count;
   logic [3:0]    dbg_state;

   image_receiver #(
      .CLKS_PER_BIT(CPB),
      .NUM_PIXELS  (NPIX),
      .START_PIXEL (START),
      .ADDR_W      (AW)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_uart_in     (uart_in),
      .o_wr_en       (wr_en),
      .o_wr_addr     (wr_addr),
      .o_wr_data     (wr_data),
      .o_frame_active(frame_active),
      .o_frame_done  (frame_done),
      .o_frame_err   (frame_err),
      .o_err_count   (err_count),
      .o_dbg_state   (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: expected writes as {addr, data}
   logic [AW+11:0] exp_q[$];

   // Reference model state
   bit         m_low   = 1'b0;
   logic [3:0] m_nib   = '0;
   bit         m_recv  = 1'b0;
   int         m_addr  = 0;
   int         m_errc  = 0;
   int         m_err_ev = 0;
   int         m_done  = 0;

   // Monitor observations
   int obs_err  = 0;
   int obs_done = 0;
   bit prev_final = 1'b0;
   bit in_stop = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_err();
      m_err_ev++;
      if (m_errc < 255) m_errc++;
      m_low  = 1'b0;
      m_recv = 1'b0;
   endtask

   // Byte-level protocol rules applied to one received byte.
   task automatic model_byte(input logic [7:0] b, input bit ok);
      logic [11:0] pix;
      if (!ok) begin
         model_err();
      end else if (!m_low) begin
         if (b[7:4] != 4'h0) model_err();
         else begin
            m_nib = b[3:0];
            m_low = 1'b1;
         end
      end else begin
         pix   = {m_nib, b};
         m_low = 1'b0;
         if (!m_recv) begin
            if (pix == START) begin
               m_recv = 1'b1;
               m_addr = 0;
            end
         end else begin
            exp_q.push_back({AW'(m_addr), pix});
            if (m_addr == NPIX - 1) begin
               m_recv = 1'b0;
               m_done++;
            end else begin
               m_addr++;
            end
         end
      end
   endtask

   task automatic model_reset();
      m_low  = 1'b0;
      m_recv = 1'b0;
      m_addr = 0;
      m_errc = 0;
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      uart_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      logic [9:0] bits;
      model_byte(b, stop_ok);
      bits = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_in = bits[i];
         in_stop = (i == 9);
         repeat (CPB) @(negedge clk);
      end
      in_stop = 1'b0;
      uart_in = 1'b1;
   endtask

   task automatic send_pixel(input logic [11:0] p);
      send_byte({4'h0, p[11:8]}, 1'b1);
      idle($urandom_range(0, 12));
      send_byte(p[7:0], 1'b1);
      idle($urandom_range(0, 12));
   endtask

   task automatic do_reset();
      @(negedge clk);
      uart_in = 1'b1;
      rst     = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"},     32'(wr_en), 32'd0);
      chk({tag, "_wr_addr"},   32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"},   32'(wr_data), 32'd0);
      chk({tag, "_active"},    32'(frame_active), 32'd0);
      chk({tag, "_done"},      32'(frame_done), 32'd0);
      chk({tag, "_err"},       32'(frame_err), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   task automatic check_state(input string tag);
      idle(30);
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_done_pulses"},    32'(obs_done), 32'(m_done));
      chk({tag, "_err_pulses"},     32'(obs_err), 32'(m_err_ev));
      chk({tag, "_err_count"},      32'(err_count), 32'(m_errc));
      chk({tag, "_active"},         32'(frame_active), 32'(m_recv));
   endtask

   initial begin
      fork
         begin : monitor
            logic [AW+11:0] e;
            forever begin
               @(negedge clk);
               if (rst) begin
                  prev_final = 1'b0;
               end else begin
                  if (prev_final) begin
                     chk("done_after_last_wr", 32'(frame_done), 32'd1);
                     chk("active_drop_with_done", 32'(frame_active), 32'd0);
                  end
                  prev_final = 1'b0;
                  if (frame_done) obs_done++;
                  if (frame_err) obs_err++;
                  if (wr_en) begin
                     chk("wr_during_stop_bit", 32'(in_stop), 32'd1);
                     chk("wr_was_expected", 32'(exp_q.size() > 0), 32'd1);
                     if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(wr_addr), 32'(e[AW+11:12]));
                        chk("wr_data", 32'(wr_data), 32'(e[11:0]));
                     end
                     prev_final = (wr_addr == AW'(NPIX - 1));
                  end
               end
            end
         end
      join_none

      // 1: reset, idle line
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle(200);
      check_reset_outputs("s1");
      check_state("s1");

      // 2: directed frame
      begin
         logic [7:0] s2 [10] = '{8'h00, 8'h0A, 8'h0F, 8'h00, 8'h00,
                                 8'h0F, 8'h0A, 8'hBC, 8'h01, 8'h23};
         for (int i = 0; i < 10; i++) send_byte(s2[i], 1'b1);
      end
      check_state("s2");
      chk("s2_last_data", 32'(wr_data), 32'h123);
      chk("s2_last_addr", 32'(wr_addr), 32'd3);

      // 3: stray pixel before marker, then a random frame
      send_pixel(12'h123);
      send_pixel(START);
      for (int i = 0; i < NPIX; i++) send_pixel(12'($urandom_range(0, 4095)));
      check_state("s3");

      // 4: framing error mid-frame, then restart
      send_pixel(START);
      send_pixel(12'($urandom_range(0, 4095)));
      send_byte(8'h0C, 1'b0);
      idle(5);
      chk("s4_active_after_err", 32'(frame_active), 32'd0);
      chk("s4_err_count", 32'(err_count), 32'd1);
      send_pixel(12'($urandom_range(0, 4095)));
      check_state("s4_abort");
      send_pixel(START);
      for (int i = 0; i < NPIX; i++) send_pixel(12'($urandom_range(0, 4095)));
      check_state("s4_restart");

      // 5: bad high byte then resync
      do_reset();
      send_byte(8'h5A, 1'b1);
      send_pixel(START);
      for (int i = 0; i < NPIX; i++) send_pixel(12'($urandom_range(0, 4095)));
      check_state("s5");
      chk("s5_err_count", 32'(err_count), 32'd1);

      // 6: short glitch, then reset in the middle of byte 5
      uart_in = 1'b0;
      repeat (3) @(negedge clk);
      idle(100);
      check_state("s6_glitch");
      send_pixel(START);
      send_pixel(12'h5C3);
      uart_in = 1'b0;
      repeat (CPB) @(negedge clk);
      uart_in = 1'b1;
      repeat (CPB) @(negedge clk);
      uart_in = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      do_reset();
      check_reset_outputs("s6_rst");
      idle(50);
      send_pixel(START);
      for (int i = 0; i < NPIX; i++) send_pixel(12'($urandom_range(0, 4095)));
      check_state("s6_after_rst");

      // 7: random frames with junk, in-frame markers and occasional errors
      for (int f = 0; f < 6; f++) begin
         int junk;
         int bad_at;
         junk   = $urandom_range(0, 2);
         bad_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NPIX - 1) : -1;
         for (int j = 0; j < junk; j++) send_pixel(12'($urandom_range(16, 4095)));
         send_pixel(START);
         for (int i = 0; i < NPIX; i++) begin
            if (i == bad_at) send_byte(8'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 4) == 0) send_pixel(START);
            else send_pixel(12'($urandom_range(0, 4095)));
         end
         check_state("s7");
      end

      // 8: error counter saturation
      do_reset();
      for (int i = 0; i < 258; i++) send_byte(8'($urandom_range(16, 255)), 1'b1);
      check_state("s8");
      chk("s8_err_saturated", 32'(err_count), 32'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART receive end of the image link. Deserialises 8N1 bytes from a GPIO pin and assembles them into 12-bit pixels.
- Detects the frame start marker, then writes NUM_PIXELS pixels sequentially into a frame-buffer write port.
- Sits on the far-end board, or on the loopback-test FPGA, facing image_sender.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- NUM_PIXELS, 76800, pixels per frame (320x240).
- START_PIXEL, 12'h00A, frame start marker value.
- ADDR_W, 17, width of wr_addr.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- rst  input  1  synchronous active-high reset.
- uart_in  input  1  asynchronous serial line, idle high.
- wr_en  output  1  one-cycle pixel write strobe.
- wr_addr  output  ADDR_W  pixel index, 0..NUM_PIXELS-1.
- wr_data  output  12  pixel {R[3:0],G[3:0],B[3:0]}.
- frame_active  output  1  high between marker acceptance and last pixel write.
- frame_done  output  1  one-cycle pulse after last pixel write.
- frame_err  output  1  one-cycle pulse on any protocol error.
- err_count  output  8  saturating error counter.

Behaviour:
- Reset: wr_en, frame_active, frame_done, frame_err = 0; wr_addr, wr_data, err_count = 0.
- Reset: synchroniser flops = 1; RX FSM = IDLE; pixel phase = HIGH; frame FSM = WAIT_SYNC.
- Reset mid-operation abandons any partial byte, pixel or frame.
- Input: 2-flop synchroniser on uart_in. All logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised low level.
  - START: wait CLKS_PER_BIT/2 cycles, resample. Low -> DATA. High -> glitch, back to IDLE, no error.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample after CLKS_PER_BIT. High -> byte valid. Low -> framing error, byte discarded. Both -> IDLE in the same cycle, so a back-to-back start bit is caught.
- Pixel wire format: 2 bytes per pixel, high byte first.
  - High byte = {4'b0000, pix[11:8]}; low byte = pix[7:0].
  - START_PIXEL is sent as 0x00, 0x0A.
- Pixel assembler:
  - HIGH phase, valid byte with upper nibble 0: latch nibble, go to LOW.
  - HIGH phase, upper nibble nonzero: protocol error, stay in HIGH (resync).
  - LOW phase, valid byte: form the pixel, go to HIGH.
  - Framing error in either phase: protocol error, force HIGH.
- Frame FSM states: WAIT_SYNC, RECEIVE.
  - WAIT_SYNC: pixel == START_PIXEL -> RECEIVE, addr counter = 0, frame_active = 1. All other pixels are ignored with no error.
  - RECEIVE: each pixel asserts wr_en for 1 cycle, with wr_addr = counter and wr_data = pixel, then the counter increments.
  - RECEIVE: a START_PIXEL value received here is ordinary data.
- Latency: wr_en is asserted exactly 1 cycle after the cycle in which the low byte's stop bit is sampled high.
- End of frame: after the write at address NUM_PIXELS-1:
  - frame_done pulses in the next cycle;
  - frame_active drops in that same cycle;
  - frame FSM returns to WAIT_SYNC.
  - The counter never wraps.
- Protocol error:
  - frame_err pulses 1 cycle later;
  - err_count increments, saturating at 255;
  - if in RECEIVE, abort to WAIT_SYNC with frame_active = 0 and no frame_done. Already-written pixels are not retracted.
- Simultaneous events: none are possible within one cycle, since at most one byte event occurs per cycle. rst has priority over everything.
- wr_addr and wr_data hold their last values when wr_en = 0.

Test Plan (CLKS_PER_BIT=8, NUM_PIXELS=4 unless noted):
1. Reset, then hold line high for 200 cycles -> all outputs 0, no wr_en.
2. Send bytes 00 0A 0F 00 00 0F 0A BC 01 23 -> exactly 4 wr_en pulses:
   - addr 0..3, data F00, 00F, ABC, 123;
   - one frame_done pulse; err_count = 0.
3. Send 01 23 before the marker, then a full valid frame -> no writes for 123; frame written as in scenario 2.
4. After marker + 1 pixel, send a byte with stop bit 0 -> frame_err pulse, err_count = 1, frame_active = 0, no further writes. A new 00 0A restarts at addr 0.
5. Send high byte 5A, then 00 0A + 4 pixels -> err_count = 1, frame received correctly (resync).
6. Line low pulse of 3 cycles -> no byte, no error. Assert rst during byte 5 of a frame -> all outputs return to reset values; next full frame is received correctly.
